// File: rtl/de2_115_sopc_irq_ctrl_if.sv
// Avalon-MM register port of the SOPC interrupt aggregator.
// The master side drives the address and write strobes; the slave side returns registered read data.
interface de2_115_sopc_irq_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/de2_115_sopc_irq_ctrl.sv
// Interrupt aggregator: synchronises, latches and masks up to 16 request lines.
// Presents the lowest-numbered active source to the Nios II as irq_out/irq_id.
module de2_115_sopc_irq_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    de2_115_sopc_irq_ctrl_if.slave  bus,
    input  logic [NUM_IRQ-1:0]      irq_in,
    output logic                    irq_out,
    output logic [3:0]              irq_id
);

    localparam logic [2:0] ADDR_PENDING = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_MODE    = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE  = 3'd3;
    localparam logic [2:0] ADDR_ID      = 3'd4;
    localparam logic [2:0] ADDR_FORCE   = 3'd5;
    localparam logic [2:0] ADDR_CTRL    = 3'd6;

    logic [NUM_IRQ-1:0] s1_reg, s2_reg, s2_d_reg;
    logic [NUM_IRQ-1:0] pending_reg, pending_next;
    logic [NUM_IRQ-1:0] enable_reg, mode_reg;
    logic               ctrl_reg;
    logic [NUM_IRQ-1:0] active;
    logic               irq_out_reg;
    logic [3:0]         irq_id_reg, irq_id_next;
    logic [15:0]        readdata_reg, readdata_next;
    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata;
    logic               unused_wdata;

    assign wr_en = bus.chipselect && !bus.write_n;
    assign wdata = bus.writedata[NUM_IRQ-1:0];
    // Upper write-data bits are deliberately dropped when fewer than 16 sources exist.
    assign unused_wdata = ^bus.writedata;

    // Per-source pending update: a fresh edge or a FORCE always wins over a W1C.
    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            logic edge_set, force_set, w1c_clr;
            assign edge_set  = s2_reg[gi] && !s2_d_reg[gi];
            assign force_set = wr_en && (bus.address == ADDR_FORCE) && wdata[gi];
            assign w1c_clr   = wr_en && (bus.address == ADDR_PENDING) && wdata[gi];
            assign pending_next[gi] = mode_reg[gi]
                ? (edge_set || force_set || (pending_reg[gi] && !w1c_clr))
                : (s2_reg[gi] || force_set);
        end
    endgenerate

    assign active = pending_reg & enable_reg & {NUM_IRQ{ctrl_reg}};

    always_comb begin
        irq_id_next = 4'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) irq_id_next = 4'(i);
        end
    end

    always_comb begin
        readdata_next = 16'd0;
        case (bus.address)
            ADDR_PENDING: readdata_next = 16'(pending_reg);
            ADDR_ENABLE:  readdata_next = 16'(enable_reg);
            ADDR_MODE:    readdata_next = 16'(mode_reg);
            ADDR_ACTIVE:  readdata_next = 16'(active);
            ADDR_ID:      readdata_next = {irq_out_reg, 11'd0, irq_id_reg};
            ADDR_CTRL:    readdata_next = {15'd0, ctrl_reg};
            default:      readdata_next = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_reg       <= '0;
            s2_reg       <= '0;
            s2_d_reg     <= '0;
            pending_reg  <= '0;
            enable_reg   <= '0;
            mode_reg     <= '0;
            ctrl_reg     <= 1'b0;
            irq_out_reg  <= 1'b0;
            irq_id_reg   <= 4'd0;
            readdata_reg <= 16'd0;
        end else begin
            s1_reg       <= irq_in;
            s2_reg       <= s1_reg;
            s2_d_reg     <= s2_reg;
            pending_reg  <= pending_next;
            irq_out_reg  <= |active;
            irq_id_reg   <= irq_id_next;
            readdata_reg <= readdata_next;
            if (wr_en && bus.address == ADDR_ENABLE) enable_reg <= wdata;
            if (wr_en && bus.address == ADDR_MODE)   mode_reg   <= wdata;
            if (wr_en && bus.address == ADDR_CTRL)   ctrl_reg   <= bus.writedata[0];
        end
    end

    assign bus.readdata = readdata_reg;
    assign irq_out      = irq_out_reg;
    assign irq_id       = irq_id_reg;

endmodule

// File: tb/tb_de2_115_sopc_irq_ctrl.sv
// Bench for the interrupt aggregator: directed scenarios plus random traffic,
// every cycle compared against a source-history reference model.
module tb_de2_115_sopc_irq_ctrl;

    localparam int N = 8;
    localparam logic [15:0] MASK = 16'h00FF;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic         irq_out;
    logic [3:0]   irq_id;

    int total = 0;
    int bad   = 0;

    de2_115_sopc_irq_ctrl_if bus();

    de2_115_sopc_irq_ctrl #(.NUM_IRQ(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_in  (irq_in),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    // Reference state; h1..h3 are the line values sampled 1, 2 and 3 edges ago.
    logic [15:0] m_pend, m_en, m_mode, m_ctrl, m_rd;
    logic        m_out;
    logic [3:0]  m_id;
    logic [N-1:0] h1, h2, h3;

    task automatic model_reset();
        m_pend = 0; m_en = 0; m_mode = 0; m_ctrl = 0; m_rd = 0;
        m_out = 0; m_id = 0; h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the pre-edge inputs, then compare all outputs.
    task automatic step();
        logic [15:0] np, act, nrd;
        logic        wr, nout, found;
        logic [3:0]  nid;
        logic [N-1:0] x;
        wr = bus.chipselect && !bus.write_n;
        x  = irq_in;
        np = 0;
        for (int i = 0; i < N; i++) begin
            logic f, c;
            f = wr && bus.address == 3'd5 && bus.writedata[i];
            c = wr && bus.address == 3'd0 && bus.writedata[i];
            if (!m_mode[i]) np[i] = h2[i] | f;
            else            np[i] = (h2[i] & ~h3[i]) | f | (m_pend[i] & ~c);
        end
        act   = m_pend & m_en & (m_ctrl[0] ? MASK : 16'h0);
        nout  = (act != 0);
        nid   = 0;
        found = 0;
        for (int i = 0; i < N; i++) begin
            if (act[i] && !found) begin nid = 4'(i); found = 1; end
        end
        case (bus.address)
            3'd0: nrd = m_pend;
            3'd1: nrd = m_en;
            3'd2: nrd = m_mode;
            3'd3: nrd = act;
            3'd4: nrd = {m_out, 11'd0, m_id};
            3'd6: nrd = m_ctrl;
            default: nrd = 0;
        endcase
        if (wr && bus.address == 3'd1) m_en   = bus.writedata & MASK;
        if (wr && bus.address == 3'd2) m_mode = bus.writedata & MASK;
        if (wr && bus.address == 3'd6) m_ctrl = bus.writedata & 16'h1;
        @(posedge clk);
        #1;
        m_pend = np; m_out = nout; m_id = nid; m_rd = nrd;
        h3 = h2; h2 = h1; h1 = x;
        chk("model_readdata", bus.readdata, m_rd);
        chk("model_irq_out", {15'd0, irq_out}, {15'd0, m_out});
        chk("model_irq_id", {12'd0, irq_id}, {12'd0, m_id});
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1; bus.write_n = 0;
        step();
        bus.chipselect = 0; bus.write_n = 1;
    endtask

    task automatic bus_rd(input logic [2:0] a);
        bus.address = a; bus.chipselect = 1; bus.write_n = 1;
        step();
        bus.chipselect = 0;
    endtask

    initial begin
        bus.address = 0; bus.chipselect = 0; bus.write_n = 1; bus.writedata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_readdata", bus.readdata, 16'h0);
        chk("reset_irq_out", {15'd0, irq_out}, 16'h0);
        chk("reset_irq_id", {12'd0, irq_id}, 16'h0);
        reset_n = 1;

        // 1. level source on bit 0
        bus_wr(3'd6, 16'h0001);
        bus_wr(3'd1, 16'h0001);
        bus_wr(3'd2, 16'h0000);
        irq_in = 8'h01;
        repeat (3) step();
        chk("t1_out_not_yet", {15'd0, irq_out}, 16'h0);
        step();
        chk("t1_out_rise", {15'd0, irq_out}, 16'h1);
        chk("t1_id", {12'd0, irq_id}, 16'h0);
        bus_rd(3'd0);
        chk("t1_pending", bus.readdata, 16'h0001);
        repeat (5) step();
        irq_in = 8'h00;
        repeat (3) step();
        chk("t1_out_hold", {15'd0, irq_out}, 16'h1);
        step();
        chk("t1_out_fall", {15'd0, irq_out}, 16'h0);

        // 2. priority between two edge sources
        bus_wr(3'd2, 16'h00FF);
        bus_wr(3'd1, 16'h00FF);
        irq_in = 8'h20; step();
        irq_in = 8'h00; step();
        irq_in = 8'h04; step();
        irq_in = 8'h00;
        repeat (5) step();
        chk("t2_id_first", {12'd0, irq_id}, 16'd2);
        bus_rd(3'd0);
        chk("t2_pending", bus.readdata, 16'h0024);
        bus_wr(3'd0, 16'h0004);
        repeat (2) step();
        chk("t2_id_second", {12'd0, irq_id}, 16'd5);
        bus_wr(3'd0, 16'h0020);
        step();
        chk("t2_out_clear", {15'd0, irq_out}, 16'h0);

        // 3. W1C lands on the same edge that latches a new edge
        irq_in = 8'h08;
        repeat (2) step();
        bus_wr(3'd0, 16'h0008);
        bus_rd(3'd0);
        chk("t3_set_wins", bus.readdata, 16'h0008);
        irq_in = 8'h00;
        bus_wr(3'd0, 16'h0008);
        step();

        // 4. global mask
        bus_wr(3'd6, 16'h0000);
        bus_wr(3'd1, 16'h0010);
        bus_wr(3'd5, 16'h0010);
        repeat (2) step();
        chk("t4_out_masked", {15'd0, irq_out}, 16'h0);
        bus_rd(3'd3);
        chk("t4_active", bus.readdata, 16'h0000);
        bus_wr(3'd6, 16'h0001);
        step();
        chk("t4_out_on", {15'd0, irq_out}, 16'h1);
        bus_rd(3'd4);
        chk("t4_id_reg", bus.readdata, 16'h8004);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            irq_in ^= N'($urandom & $urandom & $urandom);
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = 16'($urandom);
            bus.chipselect = ($urandom_range(0, 3) == 0);
            bus.write_n    = ($urandom_range(0, 1) == 0);
            step();
        end
        bus.chipselect = 0; bus.write_n = 1;

        // 5. FORCE, then asynchronous reset
        irq_in = 8'h00;
        bus_wr(3'd2, 16'h00FF);
        bus_wr(3'd1, 16'h00FF);
        bus_wr(3'd6, 16'h0001);
        repeat (4) step();
        bus_wr(3'd0, 16'h00FF);
        bus_wr(3'd5, 16'h0080);
        bus_rd(3'd0);
        chk("t5_pending", bus.readdata, 16'h0080);
        chk("t5_out", {15'd0, irq_out}, 16'h1);
        reset_n = 0;
        #1;
        chk("t5_rst_readdata", bus.readdata, 16'h0);
        chk("t5_rst_irq_out", {15'd0, irq_out}, 16'h0);
        chk("t5_rst_irq_id", {12'd0, irq_id}, 16'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1;
        bus_rd(3'd1);
        chk("t5_enable_after_rst", bus.readdata, 16'h0000);
        bus_wr(3'd7, 16'hFFFF);
        bus_rd(3'd7);
        chk("t5_addr7", bus.readdata, 16'h0000);
        bus_wr(3'd5, 16'h00FF);
        bus_rd(3'd5);
        chk("t5_force_reads0", bus.readdata, 16'h0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/de2_115_sopc_irq_ctrl.md
# de2_115_sopc_irq_ctrl

Avalon-MM slave interrupt aggregator placed directly downstream of the system-clock interval timer and the other SOPC peripherals. It latches up to 16 interrupt request lines, masks them, and resolves priority. It drives the single Nios II interrupt input together with the index of the winning source. Software clears edge-latched requests here; level sources are cleared at their originating peripheral, for example by a timer status write.

## Interface
- NUM_IRQ, 8: number of source lines, 1..16; register bits at and above NUM_IRQ read 0 and ignore writes.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  16  write data.
- irq_in  in  NUM_IRQ  source requests, active-high; may be asynchronous to clk.
- readdata  out  16  registered read data.
- irq_out  out  1  registered interrupt to the CPU.
- irq_id  out  4  registered index of the highest-priority active source.

## Operation
- Synchronizer: each irq_in bit passes through 2 flops (s1, s2). s2_d is a further delayed copy used for edge detection. All three reset to 0.
- MODE[i]=0 selects level mode: pending[i] <= s2[i] every cycle, and W1C has no effect.
- MODE[i]=1 selects edge mode: pending[i] is set on s2 & ~s2_d and holds until cleared by W1C.
- A write of 1 to FORCE[i] sets pending[i] in either mode. In level mode the forced value lasts 1 cycle.
- active = pending & ENABLE & {NUM_IRQ{CTRL[0]}}.
- Priority: the lowest-numbered active bit wins.
- irq_id <= index of the winner, or 0 if there is no winner. irq_out <= |active.
- Register map (a write occurs when chipselect && ~write_n):
  - 0 PENDING: read returns pending; write is W1C on edge-mode bits.
  - 1 ENABLE: RW, reset 0.
  - 2 MODE: RW, reset 0.
  - 3 ACTIVE: read-only.
  - 4 ID: read-only; {irq_out, 11'b0, irq_id}.
  - 5 FORCE: write-1-set; reads 0.
  - 6 CTRL: RW; bit0 is the global enable, reset 0; bits 15:1 read 0.
  - 7: reads 0; writes are ignored.
- readdata <= register mux of address on every clk, regardless of chipselect.
- A new edge and a W1C on the same bit in the same cycle: the set wins, and the bit stays pending.
- A MODE change keeps the current pending value. Edge history (s2_d) is continuous across the change.
- Asserting reset_n mid-operation clears all state immediately.
- If a line is already high when reset releases, edge mode still sees an edge, because s2_d resets to 0.

## Timing
- Reset values: readdata=0, irq_out=0, irq_id=0, pending=0, ENABLE=0, MODE=0, CTRL=0.
- Read latency is 1 cycle: address is presented at edge k and data is valid after edge k.
- Write effects are visible in the registers after the same edge.
- irq_in path, when irq_in rises before edge k:
  - s1=1 after k.
  - s2=1 after k+1.
  - pending=1 after k+2 (both modes).
  - irq_out and irq_id update after k+3.
- FORCE written at edge k: pending=1 after k, irq_out=1 after k+1.
- W1C at edge k on the only active bit: pending=0 after k, irq_out=0 after k+1.
- ENABLE or CTRL change at edge k: irq_out follows after k+1.
- A level source deasserting at irq_in before edge k drops irq_out after k+3.

## Test plan
1. Level timer source: NUM_IRQ=8, CTRL=1, ENABLE=0x0001, MODE=0; hold irq_in[0] high for 10 cycles, then low.
   - irq_out rises 3 cycles after the rise and falls 3 cycles after the fall.
   - irq_id=0.
   - PENDING reads 0x0001 while the line is high.
2. Priority: edge mode on all bits, ENABLE=0x00FF; pulse irq_in[5] and irq_in[2] for 1 cycle each.
   - irq_id=2 and PENDING=0x0024.
   - After W1C 0x0004: irq_id=5.
   - After W1C 0x0020: irq_out=0.
3. Simultaneous set/clear: edge mode on bit 3; align the W1C 0x0008 write with the cycle the s2 edge is detected.
   - PENDING still reads 0x0008.
4. Masking: pending 0x0010 with ENABLE=0x0010 and CTRL=0.
   - irq_out=0 and ACTIVE=0.
   - Write CTRL=1: irq_out=1 one cycle later, and ID reads 0x8004.
5. FORCE and reset: write FORCE=0x0080 in edge mode.
   - PENDING=0x0080 and irq_out=1.
   - Assert reset_n mid-run: all outputs are 0 immediately.
   - Reads of address 7 and FORCE return 0.
